alu_multicycle: RTL and testbench

//  Execute unit for the core datapath. Performs single-cycle integer ops, plus iterative

---
 rtl/alu_multicycle.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: integer execute unit. Single-cycle ALU ops plus iterative shift-add
// multiply and restoring divide, behind valid/ready handshakes on both sides.
// Result and flags are registered and held while the consumer stalls.
module alu_multicycle #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          MULDIV_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            alu_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  carry,
  output logic                  overflow,
  output logic                  illegal
);

  localparam int unsigned ShW  = $clog2(DATA_WIDTH);
  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(DATA_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(1);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpSlt  = 4'd8;
  localparam logic [3:0] OpSltu = 4'd9;
  localparam logic [3:0] OpMul  = 4'd10;
  localparam logic [3:0] OpRemu = 4'd13;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;

  logic                  accept;
  logic                  is_iter_op;
  logic [ShW-1:0]        shamt;

  // Single-cycle datapath
  logic [DATA_WIDTH:0]   add_full;
  logic [DATA_WIDTH:0]   sub_full;
  logic [DATA_WIDTH-1:0] sc_result;
  logic                  sc_carry;
  logic                  sc_overflow;
  logic                  sc_illegal;

  // Iterative datapath: acc holds product-high / remainder, mq holds product-low / quotient,
  // opnd holds multiplicand / divisor.
  logic [DATA_WIDTH-1:0] acc_q, mq_q, opnd_q;
  logic [CntW-1:0]       cnt_q;
  logic                  is_div_q;
  logic                  sel_hi_q;

  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH-1:0] mul_acc_nxt, mul_mq_nxt;
  logic [DATA_WIDTH:0]   div_shift;
  logic [DATA_WIDTH-1:0] div_diff;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] div_acc_nxt, div_mq_nxt;
  logic [DATA_WIDTH-1:0] step_acc, step_mq, step_res;

  // Registered outputs
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q, carry_q, overflow_q, illegal_q;

  assign shamt      = b[ShW-1:0];
  assign is_iter_op = MULDIV_EN && (alu_op >= OpMul) && (alu_op <= OpRemu);
  // abort wins over any op offered in the same cycle
  assign accept     = in_valid && in_ready && !abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = is_iter_op ? StBusy : StDone;
      end
      StBusy: begin
        if (cnt_q == CntLast) state_d = StDone;
      end
      StDone: begin
        if (accept) begin
          state_d = is_iter_op ? StBusy : StDone;
        end else if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // Handshake outputs decoded from state
  always_comb begin
    out_valid = (state_q == StDone);
    in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  end

  // Single-cycle op results and flags, computed straight from the inputs
  always_comb begin
    add_full    = {1'b0, a} + {1'b0, b};
    // carry-out of a + ~b + 1: 1 means no borrow
    sub_full    = {1'b0, a} + {1'b0, ~b} + {{DATA_WIDTH{1'b0}}, 1'b1};
    sc_result   = '0;
    sc_carry    = 1'b0;
    sc_overflow = 1'b0;
    sc_illegal  = 1'b0;
    case (alu_op)
      OpAdd: begin
        sc_result   = add_full[DATA_WIDTH-1:0];
        sc_carry    = add_full[DATA_WIDTH];
        sc_overflow = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                      (add_full[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      OpSub: begin
        sc_result   = sub_full[DATA_WIDTH-1:0];
        sc_carry    = sub_full[DATA_WIDTH];
        sc_overflow = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                      (sub_full[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      OpAnd:  sc_result = a & b;
      OpOr:   sc_result = a | b;
      OpXor:  sc_result = a ^ b;
      OpSll:  sc_result = a << shamt;
      OpSrl:  sc_result = a >> shamt;
      OpSra:  sc_result = $unsigned($signed(a) >>> shamt);
      OpSlt:  sc_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSltu: sc_result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      // 14/15 always land here; 10..13 only when the mul/div unit is disabled
      default: sc_illegal = 1'b1;
    endcase
  end

  // One multiply or divide step per BUSY cycle
  always_comb begin
    // shift-add: conditionally add multiplicand, then shift {acc, mq} right by one
    mul_sum     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc_nxt = mul_sum[DATA_WIDTH:1];
    mul_mq_nxt  = {mul_sum[0], mq_q[DATA_WIDTH-1:1]};
    // restoring divide: shift next dividend bit into the remainder, subtract if it fits.
    // A zero divisor always "fits", giving an all-ones quotient and remainder == a.
    div_shift   = {acc_q, mq_q[DATA_WIDTH-1]};
    div_ge      = (div_shift >= {1'b0, opnd_q});
    div_diff    = div_shift[DATA_WIDTH-1:0] - opnd_q;
    div_acc_nxt = div_ge ? div_diff : div_shift[DATA_WIDTH-1:0];
    div_mq_nxt  = {mq_q[DATA_WIDTH-2:0], div_ge};
    step_acc    = is_div_q ? div_acc_nxt : mul_acc_nxt;
    step_mq     = is_div_q ? div_mq_nxt : mul_mq_nxt;
    // MULHU/REMU take the acc half, MUL/DIVU the mq half
    step_res    = sel_hi_q ? step_acc : step_mq;
  end

  // Operand capture, iteration state and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      mq_q       <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      sel_hi_q   <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (abort) begin
      cnt_q <= '0;
    end else if (accept) begin
      if (is_iter_op) begin
        // ops 12/13 are the divides (bit 2), odd ops want the high/remainder half
        is_div_q <= alu_op[2];
        sel_hi_q <= alu_op[0];
        acc_q    <= '0;
        mq_q     <= alu_op[2] ? a : b;
        opnd_q   <= alu_op[2] ? b : a;
        cnt_q    <= CntInit;
      end else begin
        result_q   <= sc_result;
        zero_q     <= (sc_result == '0);
        carry_q    <= sc_carry;
        overflow_q <= sc_overflow;
        illegal_q  <= sc_illegal;
      end
    end else if (state_q == StBusy) begin
      acc_q <= step_acc;
      mq_q  <= step_mq;
      cnt_q <= cnt_q - CntLast;
      if (cnt_q == CntLast) begin
        result_q   <= step_res;
        zero_q     <= (step_res == '0);
        carry_q    <= 1'b0;
        overflow_q <= 1'b0;
        illegal_q  <= 1'b0;
      end
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed checks of alu_multicycle (32-bit, mul/div enabled) plus a
// handshake stream against a small reference model.
module tb_alu_multicycle;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   alu_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero, carry, overflow, illegal;

  int n_checks = 0;
  int n_pass = 0;
  int lat, rdy, stray, r, accepted, consumed, cyc;
  logic [W-1:0] exp_q[$];

  alu_multicycle #(
    .DATA_WIDTH(W),
    .MULDIV_EN (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .alu_op   (alu_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE; lat counts edges from the accepting edge to out_valid.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int l, output int busy_rdy);
    alu_op = op; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; a = ~av; b = ~bv; alu_op = 4'd2;
    l = 1; busy_rdy = 0;
    while (!out_valid && l < 100) begin
      if (in_ready) busy_rdy++;
      tick();
      l++;
    end
  endtask

  // Flags are {zero, carry, overflow, illegal}
  task automatic op_check(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] exp_res,
                          input logic [3:0] exp_flags, input int exp_lat);
    int l, br;
    run_op(op, av, bv, l, br);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_flags"}, {zero, carry, overflow, illegal}, exp_flags);
    check({tag, "_lat"}, l, exp_lat);
    check({tag, "_busy_ready"}, br, 0);
    tick();  // consume
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    case (op)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd4:    return x ^ y;
      4'd5:    return x << y[4:0];
      default: return '0;
    endcase
  endfunction

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {zero, carry, overflow, illegal}, 4'b0000);
    rst_n = 1'b1;
    tick();

    // single-cycle ops
    op_check("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1100, 1);
    op_check("add_ovf",  4'd0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b0010, 1);
    op_check("sub_neg",  4'd1, 32'h0,         32'h1,         32'hFFFF_FFFF, 4'b0000, 1);
    op_check("sub_pos",  4'd1, 32'h5,         32'h3,         32'h2,         4'b0100, 1);
    op_check("sub_ovf",  4'd1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b0110, 1);
    op_check("and",      4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1);
    op_check("or",       4'd3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 4'b0000, 1);
    op_check("xor",      4'd4, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 4'b0000, 1);
    op_check("sll",      4'd5, 32'h1,         32'h24,        32'h10,        4'b0000, 1);
    op_check("srl",      4'd6, 32'h8000_0000, 32'd31,        32'h1,         4'b0000, 1);
    op_check("sra",      4'd7, 32'h8000_0000, 32'd4,         32'hF800_0000, 4'b0000, 1);
    op_check("slt",      4'd8, 32'hFFFF_FFFF, 32'h1,         32'h1,         4'b0000, 1);
    op_check("sltu",     4'd9, 32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1000, 1);
    op_check("ill15",    4'd15, 32'h5,        32'h5,         32'h0,         4'b1001, 1);
    op_check("ill14",    4'd14, 32'h9,        32'h3,         32'h0,         4'b1001, 1);

    // iterative ops
    op_check("mul_ones",   4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,          4'b0000, 33);
    op_check("mulhu_ones", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,  4'b0000, 33);
    op_check("mul_dec",    4'd10, 32'd12345,     32'd678,       32'd8369910,    4'b0000, 33);
    op_check("mul_zero",   4'd10, 32'h1234_5678, 32'h0,         32'h0,          4'b1000, 33);
    op_check("divu",       4'd12, 32'd100,       32'd7,         32'd14,         4'b0000, 33);
    op_check("remu",       4'd13, 32'd100,       32'd7,         32'd2,          4'b0000, 33);
    op_check("divu_small", 4'd12, 32'd7,         32'd100,       32'd0,          4'b1000, 33);
    op_check("divu_by0",   4'd12, 32'd1234,      32'd0,         32'hFFFF_FFFF,  4'b0000, 33);
    op_check("remu_by0",   4'd13, 32'd5,         32'd0,         32'd5,          4'b0000, 33);

    // stall: result held, new op refused
    out_ready = 1'b0; alu_op = 4'd0; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    tick();
    a = 32'd100; b = 32'd100; alu_op = 4'd1;
    repeat (3) tick();
    check("stall_valid", out_valid, 1);
    check("stall_res", result, 7);
    check("stall_ready", in_ready, 0);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    check("stall_drain", out_valid, 0);

    // back-to-back issue, then single -> iterative drops out_valid
    alu_op = 4'd0; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    tick();
    alu_op = 4'd4; a = 32'd6; b = 32'd3;
    check("b2b_first", result, 3);
    check("b2b_ready", in_ready, 1);
    tick();
    check("b2b_valid", out_valid, 1);
    check("b2b_second", result, 5);
    alu_op = 4'd10; a = 32'd3; b = 32'd5;
    tick();
    in_valid = 1'b0;
    check("b2b_mul_gap", out_valid, 0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("b2b_mul_lat", lat, 33);
    check("b2b_mul_res", result, 15);
    tick();

    // abort beats an op offered in the same cycle
    abort = 1'b1; alu_op = 4'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_prio_valid", out_valid, 0);
    tick();
    check("abort_prio_late", out_valid, 0);

    // abort mid-DIVU
    alu_op = 4'd12; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("abort_busy_ready", in_ready, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_ready", in_ready, 1);
    stray = 0;
    repeat (40) begin
      tick();
      if (out_valid) stray++;
    end
    check("abort_no_result", stray, 0);
    op_check("div_after_abort", 4'd12, 32'd100, 32'd7, 32'd14, 4'b0000, 33);

    // reset mid-MUL
    alu_op = 4'd10; a = 32'd9; b = 32'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_result", result, 0);
    tick();
    rst_n = 1'b1;
    stray = 0;
    repeat (40) begin
      tick();
      if (out_valid) stray++;
    end
    check("rst_mid_no_result", stray, 0);

    // stream with random stalls against the reference model
    void'($urandom(32'd1234));
    accepted = 0; consumed = 0; cyc = 0;
    while ((accepted < 1000 || exp_q.size() > 0) && cyc < 20000) begin
      if (accepted < 1000) begin
        in_valid = ($urandom_range(0, 3) != 0);
        r = int'($urandom_range(0, 3));
        alu_op = (r == 0) ? 4'd0 : (r == 1) ? 4'd4 : (r == 2) ? 4'd5 : 4'd1;
        a = $urandom;
        b = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_spurious", 1, 0);
        end else begin
          check("stream_res", result, exp_q.pop_front());
          consumed++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(alu_op, a, b));
        accepted++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_count", consumed, 1000);
    check("stream_idle", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
